memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- Memory pipeline stage of the RISC-V core. Consumes the execute-to-memory register outputs (RegWrite_M, ResultSrc_M, MemWrite_M, AluResult_M, WriteData_M) and performs the load or store over a req/ack data-memory handshake.
- Raises Stall_M while an access is outstanding.
- Registers results into the memory-to-writeback pipeline register.

Parameters:
XLEN, 32, data and address width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
Valid_M  input  1  instruction present in M stage
RegWrite_M  input  1  instruction writes register file
ResultSrc_M  input  1  1 = load (writeback selects memory data)
MemWrite_M  input  1  1 = store
AluResult_M  input  XLEN  effective address / ALU result
WriteData_M  input  XLEN  store data
RD_M  input  5  destination register
Stall_M  output  1  hold execute/M pipeline registers (combinational)
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write
dmem_addr  output  XLEN  request address, registered
dmem_wdata  output  XLEN  write data, registered
dmem_ack  input  1  one-cycle completion pulse
dmem_rdata  input  XLEN  read data, valid when dmem_ack=1
Valid_W  output  1  W register holds a real instruction
RegWrite_W  output  1  write-enable to register file
ResultSrc_W  output  1  writeback mux select
AluResult_W  output  XLEN  registered ALU result
ReadData_W  output  XLEN  registered load data
RD_W  output  5  registered destination
stall_cycles  output  CNT_W  saturating count of cycles with Stall_M=1
mem_fault  output  1  sticky misalignment flag (feature only; else tied 0)

Behaviour:
- Reset: state=IDLE; all registered outputs 0, including dmem_req, Valid_W, RegWrite_W, ReadData_W and stall_cycles. Reset mid-access abandons the request; dmem_req drops the following cycle and the memory side must tolerate this.
- mem_op = Valid_M & (ResultSrc_M | MemWrite_M). If both ResultSrc_M and MemWrite_M are set, the op is a store.
- IDLE:
  - If mem_op: latch dmem_addr=AluResult_M, dmem_wdata=WriteData_M, dmem_we=MemWrite_M; set dmem_req=1; go to BUSY.
  - dmem_ack in IDLE is ignored.
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - On dmem_ack: dmem_req<=0, ReadData_W<=dmem_rdata if load (else unchanged), go to IDLE.
- Stall_M = (IDLE & mem_op) | (BUSY & ~dmem_ack).
- W register update, every cycle:
  - If Stall_M=0: Valid_W<=Valid_M, RegWrite_W<=RegWrite_M&Valid_M, ResultSrc_W<=ResultSrc_M, AluResult_W<=AluResult_M, RD_W<=RD_M.
  - If Stall_M=1: inject a bubble (Valid_W<=0, RegWrite_W<=0); other W fields hold.
- Latency:
  - Non-memory op: 1 cycle to W.
  - Memory op: 1 issue cycle plus N wait cycles; the W update occurs on the ack cycle, so the minimum is 2 cycles when the ack comes in the first BUSY cycle.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after ack. No pipelining of requests; at most one outstanding.
- stall_cycles increments each cycle Stall_M=1 and saturates at all-ones.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a mem_op in IDLE with AluResult_M[1:0]!=0 issues no request and stays in IDLE with Stall_M=0. The instruction retires with RegWrite_W=0, and mem_fault is set. mem_fault is sticky until rst.
- Undefined: no alignment check; the address is passed unchanged; mem_fault is constant 0.

Test Plan:
- Reset: assert rst for 2 cycles mid-BUSY -> next cycle dmem_req=0, Valid_W=0, stall_cycles=0, state IDLE.
- ALU op (Valid_M=1, RegWrite_M=1, ResultSrc_M=0, AluResult_M=0x0000_1234, RD_M=5) -> next cycle Valid_W=1, AluResult_W=0x1234, RD_W=5, Stall_M never 1.
- Load at 0x100 with ack after 3 BUSY cycles and rdata=0xDEAD_BEEF:
  - Stall_M=1 for 4 cycles; dmem_req=1, dmem_we=0, dmem_addr=0x100 stable.
  - Then ReadData_W=0xDEADBEEF, ResultSrc_W=1, Valid_W=1; stall_cycles=4.
- Store 0xCAFE_F00D to 0x200 with immediate ack -> dmem_we=1, dmem_wdata=0xCAFEF00D, total stall 1 cycle, then Valid_W=1 with RegWrite_W=0.
- Back-to-back load then store, each acked on its first BUSY cycle -> two distinct requests separated by exactly one dmem_req=0 cycle; bubbles only on the issue cycles.
- MISALIGN_TRAP_EN load at 0x102 -> no dmem_req, mem_fault=1, RegWrite_W=0; flag persists across the next valid load.

Source files
------------

// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
// memory_cycle : RISC-V memory stage, one outstanding req/ack access, M->W reg
// Optional MISALIGN_TRAP_EN : misaligned memory ops retire without access and
//                             raise the sticky mem_fault flag.
// Revision     : 1.0
// ============================================================================
module memory_cycle #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_M,
  input  logic             RegWrite_M,
  input  logic             ResultSrc_M,
  input  logic             MemWrite_M,
  input  logic [XLEN-1:0]  AluResult_M,
  input  logic [XLEN-1:0]  WriteData_M,
  input  logic [4:0]       RD_M,
  output logic             Stall_M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             Valid_W,
  output logic             RegWrite_W,
  output logic             ResultSrc_W,
  output logic [XLEN-1:0]  AluResult_W,
  output logic [XLEN-1:0]  ReadData_W,
  output logic [4:0]       RD_W,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_fault
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_mem_op;
  logic   w_trap;
  logic   w_issue;
  logic   w_done;

  // A store wins when both load and store selects are set.
  assign w_mem_op = Valid_M & (ResultSrc_M | MemWrite_M);

`ifdef MISALIGN_TRAP_EN
  logic r_fault;

  assign w_trap    = (r_state == S_IDLE) & w_mem_op & (AluResult_M[1:0] != 2'b00);
  assign mem_fault = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_trap) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_trap    = 1'b0;
  assign mem_fault = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    Stall_M     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_trap) begin
          w_issue     = 1'b1;
          Stall_M     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          Stall_M = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request fields are only written on issue, so they stay stable while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (w_issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite_M;
      dmem_addr  <= AluResult_M;
      dmem_wdata <= WriteData_M;
    end else if (w_done) begin
      dmem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData_W <= '0;
    end else if (w_done && !dmem_we) begin
      ReadData_W <= dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Valid_W     <= 1'b0;
      RegWrite_W  <= 1'b0;
      ResultSrc_W <= 1'b0;
      AluResult_W <= '0;
      RD_W        <= '0;
    end else if (!Stall_M) begin
      Valid_W     <= Valid_M;
      RegWrite_W  <= RegWrite_M & Valid_M & ~w_trap;
      ResultSrc_W <= ResultSrc_M;
      AluResult_W <= AluResult_M;
      RD_W        <= RD_M;
    end else begin
      Valid_W     <= 1'b0;
      RegWrite_W  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (Stall_M && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
// tb_memory_cycle : scoreboard bench for memory_cycle with a transaction-level
//                   memory model; small counter width exercises saturation.
// Revision        : 1.0
// ============================================================================
module tb_memory_cycle;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             Valid_M, RegWrite_M, ResultSrc_M, MemWrite_M;
  logic [XLEN-1:0]  AluResult_M, WriteData_M;
  logic [4:0]       RD_M;
  logic             Stall_M;
  logic             dmem_req, dmem_we;
  logic [XLEN-1:0]  dmem_addr, dmem_wdata;
  logic             dmem_ack;
  logic [XLEN-1:0]  dmem_rdata;
  logic             Valid_W, RegWrite_W, ResultSrc_W;
  logic [XLEN-1:0]  AluResult_W, ReadData_W;
  logic [4:0]       RD_W;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_fault;

  memory_cycle #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
    .MemWrite_M(MemWrite_M), .AluResult_M(AluResult_M), .WriteData_M(WriteData_M),
    .RD_M(RD_M), .Stall_M(Stall_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .Valid_W(Valid_W), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
    .AluResult_W(AluResult_W), .ReadData_W(ReadData_W), .RD_W(RD_W),
    .stall_cycles(stall_cycles), .mem_fault(mem_fault)
  );

  typedef struct {
    logic        rw;
    logic        rs;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } wexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  wexp_t       mon_w;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_rd;
  int          exp_stall;
  int          stall_seen;
  logic        exp_fault;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: requests are compared every cycle they are visible,
  // writeback records whenever the W register holds a real instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (Stall_M === 1'b1) stall_seen++;
      if (dmem_req === 1'b1) begin
        if (rq.size() == 0) begin
          chk("unexpected_req", 64'(dmem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("req_we", 64'(dmem_we), 64'(rq[0].we));
          chk("req_addr", 64'(dmem_addr), 64'(rq[0].addr));
          chk("req_wdata", 64'(dmem_wdata), 64'(rq[0].wdata));
          if (dmem_ack === 1'b1) void'(rq.pop_front());
        end
      end
      if (Valid_W !== 1'b0) begin
        if (wq.size() == 0) begin
          chk("unexpected_valid_w", 64'(Valid_W), 64'd0);
        end else begin
          mon_w = wq.pop_front();
          chk("w_regwrite", 64'(RegWrite_W), 64'(mon_w.rw));
          chk("w_resultsrc", 64'(ResultSrc_W), 64'(mon_w.rs));
          chk("w_alu", 64'(AluResult_W), 64'(mon_w.alu));
          chk("w_rd", 64'(RD_W), 64'(mon_w.rd));
          chk("w_readdata", 64'(ReadData_W), 64'(mon_w.rdata));
        end
      end
    end
  end

  task automatic check_counts();
    chk("stall_seen", 64'(stall_seen), 64'(exp_stall));
    chk("stall_cycles", 64'(stall_cycles), 64'((exp_stall > CNT_MAX) ? CNT_MAX : exp_stall));
    chk("mem_fault", 64'(mem_fault), 64'(exp_fault));
  endtask

  task automatic idle_inputs();
    Valid_M = 1'b0; RegWrite_M = 1'b0; ResultSrc_M = 1'b0; MemWrite_M = 1'b0;
    AluResult_M = '0; WriteData_M = '0; RD_M = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    rq.delete();
    exp_stall = 0; stall_seen = 0; last_rd = '0; exp_fault = 1'b0;
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_valid_w", 64'(Valid_W), 64'd0);
    chk("rst_regwrite_w", 64'(RegWrite_W), 64'd0);
    chk("rst_readdata_w", 64'(ReadData_W), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("rst_mem_fault", 64'(mem_fault), 64'd0);
  endtask

  // Presents one instruction to M and plays the memory side with `wt` wait
  // cycles before the ack; returns with the ack cycle still in progress.
  task automatic do_instr(input logic v, input logic rw, input logic rs, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input int wt);
    logic  memop;
    logic  trap;
    wexp_t we_rec;
    rexp_t re_rec;
    @(posedge clk); #1;
    check_counts();
    dmem_ack = 1'b0;
    Valid_M = v; RegWrite_M = rw; ResultSrc_M = rs; MemWrite_M = mw;
    AluResult_M = alu; WriteData_M = wd; RD_M = rd;
    memop = v & (rs | mw);
    trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = memop & (alu[1:0] != 2'b00);
    if (trap) exp_fault = 1'b1;
`endif
    if (memop && !trap) begin
      if (mw) begin
        mem[alu] = wd;
      end else begin
        if (!mem.exists(alu)) mem[alu] = $urandom;
        last_rd = mem[alu];
      end
      re_rec.we = mw; re_rec.addr = alu; re_rec.wdata = wd;
      rq.push_back(re_rec);
    end
    if (v) begin
      we_rec.rw = rw & ~trap; we_rec.rs = rs; we_rec.alu = alu; we_rec.rd = rd;
      we_rec.rdata = last_rd;
      wq.push_back(we_rec);
    end
    if (memop && !trap) begin
      exp_stall += 1 + wt;
      @(posedge clk); #1;
      repeat (wt) begin
        @(posedge clk); #1;
      end
      dmem_ack   = 1'b1;
      dmem_rdata = mw ? 32'($urandom) : mem[alu];
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_stall = 0; stall_seen = 0; last_rd = '0; exp_fault = 1'b0;
    rst = 1'b1;
    idle_inputs();
    apply_reset(2);

    // Directed cases
    do_instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 0);
    mem[32'h100] = 32'hDEAD_BEEF;
    do_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd6, 3);
    do_instr(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 0);
    do_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd7, 0);
    do_instr(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h1357_9BDF, 5'd0, 0);
    do_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd8, 1);
    do_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd9, 0);
    do_instr(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0108, 32'h2468_ACE0, 5'd10, 2);

    // Reset in the middle of a busy access
    @(posedge clk); #1;
    check_counts();
    Valid_M = 1'b1; RegWrite_M = 1'b1; ResultSrc_M = 1'b1; MemWrite_M = 1'b0;
    AluResult_M = 32'h0000_0300; WriteData_M = '0; RD_M = 5'd11; dmem_ack = 1'b0;
    begin
      rexp_t r;
      r.we = 1'b0; r.addr = 32'h0000_0300; r.wdata = '0;
      rq.push_back(r);
    end
    @(posedge clk); #1;
    apply_reset(2);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      int          k;
      logic        v, rw, rs, mw;
      logic [31:0] a;
      k  = $urandom_range(0, 9);
      rw = 1'($urandom);
      v  = (k != 0);
      rs = (k == 0) ? 1'($urandom) : ((k >= 4 && k <= 6) || k == 9);
      mw = (k == 0) ? 1'($urandom) : (k >= 7);
      a  = 32'($urandom) & 32'h0000_00FC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      do_instr(v, rw, rs, mw, a, 32'($urandom), 5'($urandom),
               int'($urandom_range(0, 3)));
    end

    @(posedge clk); #1;
    check_counts();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("w_queue_drained", 64'(wq.size()), 64'd0);
    chk("req_queue_drained", 64'(rq.size()), 64'd0);
    chk("final_mem_fault", 64'(mem_fault), 64'(exp_fault));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
